// File: rtl/fcpu_pkg.sv
// Shared widths and the reorder-buffer entry layout for the fcpu core.
package fcpu_pkg;

  localparam int RSV_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit buffer: dispatch allocates at the tail, the CDB completes
// entries out of order, and the register file retires them from the head.
module reorder_buffer
  import fcpu_pkg::*;
#(
  parameter int N_LOOKUP = 2,
  parameter int DEPTH_W  = RSV_ID_W
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               alloc_valid,
  input  logic [REG_W-1:0]                   alloc_reg,
  output logic                               alloc_ready,
  output logic [RSV_ID_W-1:0]                alloc_id,
  input  logic                               cdb_valid,
  input  logic [CDB_W-1:0]                   cdb,
  input  logic [N_LOOKUP-1:0][RSV_ID_W-1:0]  lookup_id,
  output logic [N_LOOKUP-1:0]                lookup_filled,
  output logic [N_LOOKUP-1:0][DATA_W-1:0]    lookup_data,
  output logic                               commit_valid,
  output logic [RSV_ID_W-1:0]                commit_id,
  output logic [REG_W-1:0]                   commit_reg,
  output logic [DATA_W-1:0]                  commit_data,
  input  logic                               commit_ready,
  input  logic                               flush,
  output logic [DEPTH_W:0]                   count
);

  localparam int ENTRIES = 2 ** DEPTH_W;

  rob_entry_t           entries [ENTRIES];
  logic [DEPTH_W-1:0]   head;
  logic [DEPTH_W-1:0]   tail;
  rob_entry_t           head_entry;
  logic [RSV_ID_W-1:0]  cdb_id;
  logic [DATA_W-1:0]    cdb_data;
  logic [DEPTH_W-1:0]   cdb_idx;
  logic                 cdb_hit;
  logic                 alloc_fire;
  logic                 commit_fire;

  // Ids wider than the buffer index never name a live entry.
  function automatic logic id_in_range(input logic [RSV_ID_W-1:0] id);
    return (id >> DEPTH_W) == '0;
  endfunction

  assign cdb_id   = cdb[DATA_W +: RSV_ID_W];
  assign cdb_data = cdb[0 +: DATA_W];
  assign cdb_idx  = cdb_id[DEPTH_W-1:0];
  assign cdb_hit  = cdb_valid & id_in_range(cdb_id) &
                    entries[cdb_idx].valid & ~entries[cdb_idx].done;

  // Ready comes from the registered count only, so a slot freed by a commit
  // becomes allocatable one cycle later.
  assign alloc_ready = (count < (DEPTH_W+1)'(ENTRIES)) & ~flush & ~nrst;
  assign alloc_id    = RSV_ID_W'(tail);
  assign alloc_fire  = alloc_valid & alloc_ready;

  assign head_entry   = entries[head];
  assign commit_valid = head_entry.valid & head_entry.done & ~flush & ~nrst;
  assign commit_id    = RSV_ID_W'(head);
  assign commit_reg   = head_entry.rd;
  assign commit_data  = head_entry.data;
  assign commit_fire  = commit_valid & commit_ready;

  // Alloc, completion and commit never target the same entry in one cycle:
  // the tail slot is invalid, the head slot being retired is already done.
  always_ff @(posedge clk) begin
    if (nrst || flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (cdb_hit) begin
        entries[cdb_idx].done <= 1'b1;
        entries[cdb_idx].data <= cdb_data;
      end
      if (commit_fire) begin
        entries[head] <= '0;
        head          <= head + 1'b1;
      end
      if (alloc_fire) begin
        entries[tail] <= '{valid: 1'b1, done: 1'b0, rd: alloc_reg, data: '0};
        tail          <= tail + 1'b1;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count <= count + (DEPTH_W+1)'(1);
        2'b01:   count <= count - (DEPTH_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  for (genvar k = 0; k < N_LOOKUP; k++) begin : g_lookup
    logic [DEPTH_W-1:0] idx;
    rob_entry_t         ent;
    logic               in_range;
    logic               filled;
    logic [DATA_W-1:0]  data;

    assign idx      = lookup_id[k][DEPTH_W-1:0];
    assign ent      = entries[idx];
    assign in_range = id_in_range(lookup_id[k]);

    // Stored results win; otherwise forward a same-cycle CDB broadcast.
    always_comb begin
      filled = 1'b0;
      data   = '0;
      if (in_range && ent.valid && ent.done) begin
        filled = 1'b1;
        data   = ent.data;
      end else if (cdb_valid && (cdb_id == lookup_id[k])) begin
        filled = 1'b1;
        data   = cdb_data;
      end
    end

    assign lookup_filled[k] = filled;
    assign lookup_data[k]   = data;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized scoreboard bench for reorder_buffer against a queue-based
// program-order model of the buffer contents.
module tb_reorder_buffer;
  import fcpu_pkg::*;

  localparam int NL    = 2;
  localparam int DEPTH = 16;

  logic                         clk = 1'b0;
  logic                         nrst;
  logic                         alloc_valid;
  logic [REG_W-1:0]             alloc_reg;
  logic                         alloc_ready;
  logic [RSV_ID_W-1:0]          alloc_id;
  logic                         cdb_valid;
  logic [CDB_W-1:0]             cdb;
  logic [NL-1:0][RSV_ID_W-1:0]  lookup_id;
  logic [NL-1:0]                lookup_filled;
  logic [NL-1:0][DATA_W-1:0]    lookup_data;
  logic                         commit_valid;
  logic [RSV_ID_W-1:0]          commit_id;
  logic [REG_W-1:0]             commit_reg;
  logic [DATA_W-1:0]            commit_data;
  logic                         commit_ready;
  logic                         flush;
  logic [RSV_ID_W:0]            count;

  always #5 clk = ~clk;

  reorder_buffer #(.N_LOOKUP(NL), .DEPTH_W(RSV_ID_W)) dut (
    .clk(clk), .nrst(nrst),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
    .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .cdb_valid(cdb_valid), .cdb(cdb),
    .lookup_id(lookup_id), .lookup_filled(lookup_filled), .lookup_data(lookup_data),
    .commit_valid(commit_valid), .commit_id(commit_id),
    .commit_reg(commit_reg), .commit_data(commit_data),
    .commit_ready(commit_ready), .flush(flush), .count(count)
  );

  typedef struct {
    int          id;
    int          rd;
    bit          done;
    logic [31:0] data;
  } model_entry_t;

  typedef struct {
    int          id;
    int          rd;
    logic [31:0] data;
  } commit_t;

  model_entry_t rob_q[$];
  commit_t      exp_q[$];
  int           next_id     = 0;
  bit           model_known = 1'b0;
  bit           exp_ar;
  bit           exp_cv;
  int           checks      = 0;
  int           failures    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void expLookup(input int lid, output bit f, output logic [31:0] d);
    f = 1'b0;
    d = '0;
    foreach (rob_q[i]) begin
      if (rob_q[i].id == lid && rob_q[i].done) begin
        f = 1'b1;
        d = rob_q[i].data;
      end
    end
    if (!f && cdb_valid && (int'(cdb[DATA_W +: RSV_ID_W]) == lid)) begin
      f = 1'b1;
      d = cdb[0 +: DATA_W];
    end
  endfunction

  // Compares the combinational view of the current cycle with the model.
  task automatic checkOutput();
    bit          f;
    logic [31:0] d;
    exp_ar = (rob_q.size() < DEPTH) && !flush && !nrst;
    exp_cv = model_known && (rob_q.size() > 0) && rob_q[0].done && !flush && !nrst;
    check("alloc_ready", 64'(alloc_ready), 64'(exp_ar));
    check("commit_valid", 64'(commit_valid), 64'(exp_cv));
    if (model_known) begin
      check("alloc_id", 64'(alloc_id), 64'(next_id));
      check("count", 64'(count), 64'(rob_q.size()));
      for (int k = 0; k < NL; k++) begin
        expLookup(int'(lookup_id[k]), f, d);
        check($sformatf("lookup_filled%0d", k), 64'(lookup_filled[k]), 64'(f));
        check($sformatf("lookup_data%0d", k), 64'(lookup_data[k]), 64'(d));
      end
    end
  endtask

  // One clock cycle: drive, check, then advance the model by the handshakes.
  task automatic applyStimulus(input bit av, input int rg, input bit cv, input int cid,
                               input logic [31:0] cd, input bit cr, input bit fl,
                               input bit rs, input int l0, input int l1);
    commit_t e;
    @(posedge clk);
    #1;
    alloc_valid  = av;
    alloc_reg    = REG_W'(rg);
    cdb_valid    = cv;
    cdb          = {RSV_ID_W'(cid), cd};
    commit_ready = cr;
    flush        = fl;
    nrst         = rs;
    lookup_id[0] = RSV_ID_W'(l0);
    lookup_id[1] = RSV_ID_W'(l1);
    #1;
    checkOutput();
    if (rs || fl) begin
      rob_q.delete();
      next_id     = 0;
      model_known = 1'b1;
    end else begin
      if (cv) begin
        foreach (rob_q[i]) begin
          if (rob_q[i].id == cid && !rob_q[i].done) begin
            rob_q[i].done = 1'b1;
            rob_q[i].data = cd;
          end
        end
      end
      if (cr && exp_cv) begin
        e.id   = rob_q[0].id;
        e.rd   = rob_q[0].rd;
        e.data = rob_q[0].data;
        void'(rob_q.pop_front());
        exp_q.push_back(e);
      end
      if (av && exp_ar) begin
        rob_q.push_back('{id: next_id, rd: rg, done: 1'b0, data: '0});
        next_id = (next_id + 1) % DEPTH;
      end
    end
  endtask

  task automatic idle(input bit cr);
    applyStimulus(0, 0, 0, 0, 0, cr, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  function automatic int pickId();
    if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
      return rob_q[$urandom_range(0, rob_q.size() - 1)].id;
    return int'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic randomCycle(input int av_pct, input int cr_pct);
    applyStimulus($urandom_range(0, 99) < av_pct, int'($urandom_range(0, 31)),
                  $urandom_range(0, 99) < 50, pickId(), $urandom,
                  $urandom_range(0, 99) < cr_pct, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 299) == 0, pickId(), pickId());
  endtask

  // Scoreboard monitor: every accepted commit must match the model's next retirement.
  initial begin
    forever begin
      @(negedge clk);
      if (commit_valid === 1'b1 && commit_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL commit_unexpected actual=id%0d expected=none at %0t", commit_id, $time);
        end else begin
          commit_t e;
          e = exp_q.pop_front();
          check("commit_id", 64'(commit_id), 64'(e.id));
          check("commit_reg", 64'(commit_reg), 64'(e.rd));
          check("commit_data", 64'(commit_data), 64'(e.data));
        end
      end else if (exp_q.size() != 0) begin
        commit_t e;
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("[TB] FAIL commit_missing actual=none expected=id%0d at %0t", e.id, $time);
      end
    end
  end

  initial begin
    nrst = 1'b1; alloc_valid = 1'b0; alloc_reg = '0; cdb_valid = 1'b0; cdb = '0;
    commit_ready = 1'b0; flush = 1'b0; lookup_id = '0;

    // Single entry: alloc, complete, retire.
    doReset();
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'hDEAD, 1, 0, 0, 0, 1);
    idle(1);
    idle(1);

    // Out-of-order completion, in-order retirement.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1, i + 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 2, 32'h22, 1, 0, 0, 2, 0);
    applyStimulus(0, 0, 1, 0, 32'h10, 1, 0, 0, 2, 0);
    applyStimulus(0, 0, 1, 1, 32'h11, 1, 0, 0, 1, 2);
    for (int i = 0; i < 3; i++) idle(1);

    // Fill, retire while full with alloc pending, wrap tail; bypass and stray CDB.
    doReset();
    applyStimulus(0, 0, 1, 7, 32'h77, 0, 0, 0, 7, 7);
    idle(0);
    for (int i = 0; i < 16; i++) applyStimulus(1, i, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 9, 1, 0, 32'hA0, 0, 0, 0, 3, 0);
    applyStimulus(1, 9, 1, 3, 32'h55, 1, 0, 0, 3, 0);
    applyStimulus(1, 10, 0, 0, 0, 0, 0, 0, 3, 0);
    idle(0);

    // Flush overrides alloc, CDB and commit.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, i, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'hBEEF, 0, 0, 0, 0, 0);
    applyStimulus(1, 3, 1, 1, 32'h1, 1, 1, 0, 0, 1);
    idle(1);

    // Alloc and commit together at count 8.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1, i, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h80, 0, 0, 0, 0, 0);
    applyStimulus(1, 20, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(0);

    // Random traffic: a filling phase, then balanced traffic.
    for (int i = 0; i < 400; i++) randomCycle(80, 20);
    for (int i = 0; i < 1500; i++) randomCycle(55, 70);
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 1, pickId(), $urandom, 1, 0, 0, pickId(), pickId());

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter N_LOOKUP, default 2, number of operand-lookup ports.
REQ-002 SHALL have parameter DEPTH_W, default RSV_ID_W, log2 of entry count; DEPTH_W <= RSV_ID_W.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 nrst  in  1  reset nrst, synchronous, active-high.
REQ-005 alloc_valid  in  1  dispatch requests an entry.
REQ-006 alloc_reg  in  REG_W  architectural destination register.
REQ-007 alloc_ready  out  1  an entry is free.
REQ-008 alloc_id  out  RSV_ID_W  id granted on the alloc handshake (tail pointer).
REQ-009 cdb_valid  in  1  common data bus broadcast valid.
REQ-010 cdb  in  CDB_W  {id at [DATA_W+:RSV_ID_W], data at [0+:DATA_W]}.
REQ-011 lookup_id  in  N_LOOKUP x RSV_ID_W  operand ids queried by dispatch.
REQ-012 lookup_filled / lookup_data  out  N_LOOKUP x 1 / N_LOOKUP x DATA_W  result available, value.
REQ-013 commit_valid  out  1  head entry complete.
REQ-014 commit_id / commit_reg / commit_data  out  RSV_ID_W / REG_W / DATA_W  head entry contents.
REQ-015 commit_ready  in  1  register file accepts commit.
REQ-016 flush  in  1  discard all entries (mispredict).
REQ-017 count  out  DEPTH_W+1  occupied entries.

Function
REQ-018 Circular buffer of 2**DEPTH_W entries {valid, done, reg, data}; head/tail pointers DEPTH_W bits, wrap modulo 2**DEPTH_W.
REQ-019 alloc_ready = (count < 2**DEPTH_W) & ~flush; derived from registered count only, no combinational path from commit_ready.
REQ-020 Alloc handshake (alloc_valid & alloc_ready): entry[tail] <= {1,0,alloc_reg,0}; tail++ next cycle.
REQ-021 CDB write: if cdb_valid, entry[id].valid and ~entry[id].done: done<=1, data<=cdb data; broadcast to invalid or done entry ignored.
REQ-022 lookup_filled[k]=1 with stored data if entry[lookup_id[k]] valid & done; else 1 with cdb data if cdb_valid and cdb id == lookup_id[k] (same-cycle bypass); else 0, data 0.
REQ-023 commit_valid = entry[head].valid & entry[head].done & ~flush; commit_* from entry[head].
REQ-024 Commit handshake: entry[head] cleared to 0, head++; earliest commit is cycle after the CDB write (1-cycle latency).
REQ-025 count: +1 on alloc only, -1 on commit only, unchanged on both same cycle.
REQ-026 Full (count=2**DEPTH_W) with commit in same cycle: alloc_ready stays 0 that cycle; freed entry usable next cycle.
REQ-027 Empty: commit_valid=0; alloc then CDB then commit of same id SHALL take 3 cycles minimum.
REQ-028 flush: next cycle all entries invalid, head=tail=count=0; flush overrides alloc, CDB and commit in the same cycle.

Reset
REQ-029 nrst high: next cycle state equals flush result; while nrst high alloc_ready=0, commit_valid=0.
REQ-030 Post-reset outputs: alloc_ready=1, alloc_id=0, commit_valid=0, count=0, lookup_filled=0 absent CDB match.
REQ-031 nrst mid-operation discards all entries; no commit handshake accepted in the reset cycle.

Structure
REQ-032 RSV_ID_W, DATA_W, REG_W, CDB_W and typedef rob_entry_t SHALL live in fcpu_pkg.
REQ-033 Single flat module; no sub-module; lookup ports via generate loop.

Verification (RSV_ID_W=DEPTH_W=4, DATA_W=32)
REQ-034 Reset, alloc reg 5 -> alloc_id=0; CDB {0,0xDEAD} -> next cycle commit_valid=1, commit_reg=5, commit_data=0xDEAD.
REQ-035 Alloc ids 0,1,2; CDB 2 then 0 then 1 -> commits strictly in order 0,1,2, count 3->0.
REQ-036 16 allocs, commit_ready held 0 -> alloc_ready=0, count=16; commit one with alloc_valid=1 -> alloc_ready 0 that cycle, next alloc_id=0 (wrap).
REQ-037 lookup_id=3 while CDB {3,0x55} -> lookup_filled=1, data 0x55 same cycle; CDB to free id 7 -> no state change.
REQ-038 Alloc+CDB+commit+flush same cycle, 4 entries live -> next cycle count=0, commit_valid=0, alloc_id=0.
REQ-039 Alloc and commit same cycle at count=8 -> count stays 8.
